// File: rtl/capi_command_arbiter_pkg.sv
// Shared CAPI types for the command arbiter: PSL command/response structs,
// command codes, arbiter state encoding and credit width.
package CAPI;

    typedef logic [63:0] pointer_t;

    localparam int CREDIT_WIDTH = 8;

    localparam logic [12:0] READ_CL_NA = 13'h0A00;
    localparam logic [12:0] READ_CL_S  = 13'h0A50;
    localparam logic [12:0] READ_PNA   = 13'h0E00;
    localparam logic [12:0] WRITE_NA   = 13'h0D00;
    localparam logic [12:0] WRITE_MI   = 13'h0D60;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arbiter_state;

    typedef struct packed {
        logic        valid;
        logic [7:0]  tag;
        logic        tag_parity;
        logic [12:0] command;
        logic        command_parity;
        logic [2:0]  abt;
        pointer_t    address;
        logic        address_parity;
        logic [15:0] context_handle;
        logic [11:0] size;
    } CommandInterfaceOutput;

    typedef struct packed {
        logic       valid;
        logic [7:0] tag;
        logic       tag_parity;
        logic [7:0] response;
    } ResponseInterface;

endpackage

// File: rtl/capi_command_arbiter_if.sv
// Per-requester command handshake bundle between AFU requesters and the arbiter.
interface capi_command_arbiter_if
    import CAPI::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0][12:0]   req_command;
    logic [NUM_REQ-1:0][7:0]    req_tag;
    logic [NUM_REQ-1:0][11:0]   req_size;
    pointer_t [NUM_REQ-1:0]     req_address;

    modport master (
        output req_valid, req_command, req_tag, req_size, req_address,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_command, req_tag, req_size, req_address,
        output req_ready
    );
endinterface

// File: rtl/capi_command_arbiter_rr.sv
// Round-robin picker: first set request at or after i_ptr, wrapping; one-hot result.
module round_robin_select #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant
);
    logic          w_found;
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(N)) begin
                w_sum = w_sum - (PW+1)'(N);
            end
            w_idx = w_sum[PW-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/capi_command_arbiter.sv
// Credit-based command arbiter between NUM_REQ AFU requesters and the PSL command port.
// Optional outstanding-tag scoreboard enabled by defining ARB_TAG_CHECK_EN.
//
// state | meaning
// IDLE  | AFU not running, no grants
// RUN   | granting while credits remain
// DRAIN | enable dropped, waiting for all credits to return
module capi_command_arbiter
    import CAPI::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_CREDITS = 64
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enabled,
    input  logic [7:0]              croom,
    capi_command_arbiter_if.slave   req,
    input  ResponseInterface        response,
    output CommandInterfaceOutput   command_out,
    output logic [CREDIT_WIDTH-1:0] credits,
    output logic                    busy,
    output logic                    credit_error
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CREDIT_WIDTH-1:0] MAX_C = CREDIT_WIDTH'(MAX_CREDITS);

    arbiter_state              r_state, w_state_nxt;
    logic [CREDIT_WIDTH-1:0]   r_credits, r_limit, w_limit_rst;
    logic [PW-1:0]             r_ptr, w_ptr_nxt;
    logic                      r_err;
    CommandInterfaceOutput     r_cmd;

    logic                      w_grant_en;
    logic [NUM_REQ-1:0]        w_tag_ok, w_req_elig, w_grant_raw, w_grant;
    logic                      w_xfer, w_tag_bad, w_resp_over, w_resp_inc;
    logic [12:0]               w_sel_cmd;
    logic [7:0]                w_sel_tag;
    logic [11:0]               w_sel_size;
    pointer_t                  w_sel_addr;
    logic [PW-1:0]             w_sel_idx;
    logic                      w_unused_resp;

    assign w_limit_rst = (croom < MAX_C) ? croom : MAX_C;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (enabled) w_state_nxt = RUN;
            end
            RUN: begin
                if (!enabled) w_state_nxt = DRAIN;
                else          w_grant_en  = reset_n && (r_credits != '0);
            end
            DRAIN: begin
                if (enabled)                     w_state_nxt = RUN;
                else if (r_credits == r_limit)   w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef ARB_TAG_CHECK_EN
    logic [255:0] r_tag_out;

    always_comb begin
        w_tag_ok = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_tag_ok[i] = ~r_tag_out[req.req_tag[i]];
        end
    end

    assign w_tag_bad = response.valid & ~r_tag_out[response.tag];

    // Clear before set: a tag can only be issued when it is not outstanding.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_tag_out <= '0;
        end else begin
            if (response.valid) r_tag_out[response.tag] <= 1'b0;
            if (w_xfer)         r_tag_out[w_sel_tag]    <= 1'b1;
        end
    end

    assign w_unused_resp = ^{response.tag_parity, response.response};
`else
    assign w_tag_ok      = '1;
    assign w_tag_bad     = 1'b0;
    assign w_unused_resp = ^{response.tag_parity, response.response, response.tag};
`endif

    assign w_req_elig = req.req_valid & w_tag_ok;

    round_robin_select #(.N(NUM_REQ), .PW(PW)) u_rr (
        .i_req   (w_req_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_grant_raw)
    );

    assign w_grant       = w_grant_en ? w_grant_raw : '0;
    assign req.req_ready = w_grant;
    assign w_xfer        = |(w_grant & req.req_valid);

    always_comb begin
        w_sel_cmd  = '0;
        w_sel_tag  = '0;
        w_sel_size = '0;
        w_sel_addr = '0;
        w_sel_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_cmd  = req.req_command[i];
                w_sel_tag  = req.req_tag[i];
                w_sel_size = req.req_size[i];
                w_sel_addr = req.req_address[i];
                w_sel_idx  = PW'(i);
            end
        end
    end

    assign w_ptr_nxt = (w_sel_idx == PW'(NUM_REQ-1)) ? '0 : w_sel_idx + PW'(1);

    // A response alongside a transfer nets to zero and can never overflow.
    assign w_resp_over = response.valid && !w_xfer && (r_credits == r_limit);
    assign w_resp_inc  = response.valid && !w_resp_over && !w_tag_bad;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_limit   <= w_limit_rst;
            r_credits <= w_limit_rst;
            r_err     <= 1'b0;
            r_ptr     <= '0;
            r_cmd     <= '0;
        end else begin
            if (w_xfer && !w_resp_inc) begin
                r_credits <= r_credits - CREDIT_WIDTH'(1);
            end else if (!w_xfer && w_resp_inc) begin
                r_credits <= r_credits + CREDIT_WIDTH'(1);
            end
            if (w_resp_over || w_tag_bad) r_err <= 1'b1;
            r_cmd.valid <= w_xfer;
            if (w_xfer) begin
                r_ptr                <= w_ptr_nxt;
                r_cmd.command        <= w_sel_cmd;
                r_cmd.command_parity <= ~^w_sel_cmd;
                r_cmd.tag            <= w_sel_tag;
                r_cmd.tag_parity     <= ~^w_sel_tag;
                r_cmd.size           <= w_sel_size;
                r_cmd.address        <= w_sel_addr;
                r_cmd.address_parity <= ~^w_sel_addr;
            end
        end
    end

    assign command_out  = r_cmd;
    assign credits      = r_credits;
    assign busy         = (r_state != IDLE);
    assign credit_error = r_err;
endmodule

// File: tb/tb_capi_command_arbiter.sv
// Directed bench for capi_command_arbiter with a command_out scoreboard.
module tb_capi_command_arbiter;
    import CAPI::*;

    logic                  clock, reset_n, enabled;
    logic [7:0]            croom;
    ResponseInterface      response;
    CommandInterfaceOutput command_out;
    logic [7:0]            credits;
    logic                  busy, credit_error;

    capi_command_arbiter_if #(.NUM_REQ(4)) req_if ();

    capi_command_arbiter dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enabled      (enabled),
        .croom        (croom),
        .req          (req_if),
        .response     (response),
        .command_out  (command_out),
        .credits      (credits),
        .busy         (busy),
        .credit_error (credit_error)
    );

    int n_vec = 0;
    int n_err = 0;
    CommandInterfaceOutput sb[$];

    logic [12:0] b_cmd  [4];
    logic [7:0]  b_tag  [4];
    logic [11:0] b_size [4];
    pointer_t    b_addr [4];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic load_fields();
        for (int i = 0; i < 4; i++) begin
            req_if.req_command[i] = b_cmd[i];
            req_if.req_tag[i]     = b_tag[i];
            req_if.req_size[i]    = b_size[i];
            req_if.req_address[i] = b_addr[i];
        end
    endtask

    function automatic CommandInterfaceOutput exp_cmd(input int i);
        CommandInterfaceOutput c;
        c                = '0;
        c.valid          = 1'b1;
        c.command        = b_cmd[i];
        c.command_parity = ~^b_cmd[i];
        c.tag            = b_tag[i];
        c.tag_parity     = ~^b_tag[i];
        c.size           = b_size[i];
        c.address        = b_addr[i];
        c.address_parity = ~^b_addr[i];
        return c;
    endfunction

    task automatic do_reset(input logic [7:0] cr, input logic [7:0] exp_cr);
        reset_n           = 1'b0;
        enabled           = 1'b0;
        croom             = cr;
        req_if.req_valid  = '0;
        response          = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_credits", credits, exp_cr);
        check("rst_busy", busy, 0);
        check("rst_valid", command_out.valid, 0);
        check("rst_fields_zero", (command_out == '0), 1);
        check("rst_ready", req_if.req_ready, 0);
        check("rst_credit_error", credit_error, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic wait_ready(input int idx);
        int n;
        n = 0;
        #1;
        while (!req_if.req_ready[idx] && n < 20) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("ready_wait_req%0d", idx), req_if.req_ready[idx], 1);
    endtask

    task automatic issue(input int idx);
        req_if.req_valid[idx] = 1'b1;
        sb.push_back(exp_cmd(idx));
        wait_ready(idx);
        @(posedge clock);
        #1 req_if.req_valid[idx] = 1'b0;
    endtask

    // Scoreboard monitor: every command_out.valid must match the oldest expectation.
    initial begin
        CommandInterfaceOutput e;
        forever begin
            @(negedge clock);
            if (command_out.valid) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL cmd_unexpected: got command_out %h, required no command", command_out);
                end else begin
                    e = sb.pop_front();
                    if (command_out !== e) begin
                        n_err++;
                        $display("FAIL cmd_out: got %h required %h", command_out, e);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            b_cmd[i]  = READ_CL_S + 13'(i);
            b_tag[i]  = 8'h10 + 8'(i);
            b_size[i] = 12'd128;
            b_addr[i] = 64'h2000_0000 + 64'(i) * 64'h80;
        end
        load_fields();
        response = '0;
        enabled  = 1'b0;
        reset_n  = 1'b0;
        croom    = '0;

        // croom above MAX_CREDITS clamps to 64
        do_reset(8'd200, 8'd64);

        // four requesters, four credits, then starvation until a response
        do_reset(8'd4, 8'd4);
        enabled = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) sb.push_back(exp_cmd(i));
        req_if.req_valid = 4'hF;
        repeat (6) tick();
        @(negedge clock);
        check("zero_credits", credits, 0);
        check("no_grant_at_zero", req_if.req_ready, 0);
        check("busy_run", busy, 1);
        sb.push_back(exp_cmd(0));
        response.valid = 1'b1;
        @(posedge clock);
        #1 response.valid = 1'b0;
        @(negedge clock);
        check("credit_after_resp", credits, 1);
        check("rr_wrap_ready", req_if.req_ready, 4'b0001);
        @(posedge clock);
        #1 req_if.req_valid = '0;
        @(negedge clock);
        check("credits_reused", credits, 0);

        // transfer and response in the same cycle
        do_reset(8'd4, 8'd4);
        enabled = 1'b1;
        tick();
        issue(0);
        issue(1);
        @(negedge clock);
        check("credits_two", credits, 2);
        req_if.req_valid[2] = 1'b1;
        sb.push_back(exp_cmd(2));
        wait_ready(2);
        response.valid = 1'b1;
        @(posedge clock);
        #1;
        req_if.req_valid[2] = 1'b0;
        response.valid      = 1'b0;
        @(negedge clock);
        check("same_cycle_credits", credits, 2);
        check("same_cycle_cmd_valid", command_out.valid, 1);

        // drain with three outstanding, then overflow response
        do_reset(8'd8, 8'd8);
        enabled = 1'b1;
        tick();
        issue(0);
        issue(1);
        issue(2);
        enabled = 1'b0;
        tick();
        req_if.req_valid[3] = 1'b1;
        repeat (2) tick();
        @(negedge clock);
        check("drain_busy", busy, 1);
        check("drain_no_grant", req_if.req_ready, 0);
        check("drain_credits", credits, 5);
        response.valid = 1'b1;
        repeat (3) tick();
        response.valid = 1'b0;
        repeat (2) tick();
        req_if.req_valid[3] = 1'b0;
        @(negedge clock);
        check("idle_after_drain", busy, 0);
        check("credits_restored", credits, 8);
        check("no_error_yet", credit_error, 0);
        response.valid = 1'b1;
        tick();
        response.valid = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        check("overflow_credits", credits, 8);
        check("overflow_error_sticky", credit_error, 1);

        // requester 2 alone with READ_CL_NA, then round-robin 3 before 0
        b_cmd[2]  = READ_CL_NA;
        b_tag[2]  = 8'h05;
        b_addr[2] = 64'h1000;
        load_fields();
        do_reset(8'd8, 8'd8);
        enabled = 1'b1;
        tick();
        issue(2);
        @(negedge clock);
        check("cmd_latency_one", command_out.valid, 1);
        check("tag_parity_05", command_out.tag_parity, 1);
        check("cmd_tag_05", command_out.tag, 8'h05);
        @(negedge clock);
        check("cmd_valid_one_cycle", command_out.valid, 0);
        sb.push_back(exp_cmd(3));
        sb.push_back(exp_cmd(0));
        req_if.req_valid = 4'b1001;
        #1 check("rr_after_2", req_if.req_ready, 4'b1000);
        @(negedge clock);
        check("rr_then_0", req_if.req_ready, 4'b0001);
        @(posedge clock);
        #1 req_if.req_valid = '0;
        @(negedge clock);
        check("rr_credits", credits, 5);

        // reset falling while a grant is presented aborts it
        do_reset(8'd8, 8'd8);
        enabled = 1'b1;
        tick();
        req_if.req_valid[0] = 1'b1;
        wait_ready(0);
        reset_n = 1'b0;
        #1 check("abort_ready", req_if.req_ready, 0);
        @(posedge clock);
        @(negedge clock);
        check("abort_no_valid", command_out.valid, 0);
        check("abort_credits", credits, 8);
        req_if.req_valid = '0;

`ifdef ARB_TAG_CHECK_EN
        b_tag[0] = 8'h07;
        b_tag[1] = 8'h07;
        load_fields();
        do_reset(8'd8, 8'd8);
        enabled = 1'b1;
        tick();
        issue(0);
        req_if.req_valid[1] = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        check("tag_blocked", req_if.req_ready, 0);
        sb.push_back(exp_cmd(1));
        response.tag   = 8'h07;
        response.valid = 1'b1;
        @(posedge clock);
        #1 response.valid = 1'b0;
        wait_ready(1);
        @(posedge clock);
        #1 req_if.req_valid[1] = 1'b0;
        @(negedge clock);
        check("tag_no_error", credit_error, 0);
        response.tag   = 8'h09;
        response.valid = 1'b1;
        tick();
        response.valid = 1'b0;
        @(negedge clock);
        check("tag_unknown_error", credit_error, 1);
`endif

        repeat (3) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
